// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: opcodes, FSM states
// and the default access timeout.
package mem_arbiter_pkg;

    localparam int TIMEOUT_DEFAULT = 16;

    localparam logic [5:0] OP_LD   = 6'b001000;
    localparam logic [5:0] OP_LDSB = 6'b001001;
    localparam logic [5:0] OP_LDSH = 6'b001010;
    localparam logic [5:0] OP_LDUB = 6'b000001;
    localparam logic [5:0] OP_LDUH = 6'b000010;
    localparam logic [5:0] OP_ST   = 6'b000100;
    localparam logic [5:0] OP_STB  = 6'b000101;
    localparam logic [5:0] OP_STH  = 6'b000110;
    localparam logic [5:0] OP_LDD  = 6'b000011;
    localparam logic [5:0] OP_STD  = 6'b000111;

    // Instruction fetches are always plain word loads.
    localparam logic [5:0] OP_FETCH = OP_LD;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_ACCESS  = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    typedef enum logic {
        PORT_FETCH = 1'b0,
        PORT_DATA  = 1'b1
    } port_t;

endpackage

// File: rtl/mem_op_check.sv
// Combinational opcode legality and alignment check for a latched request.
// Double-word ops (ldd/std) are deliberately rejected.
module mem_op_check
    import mem_arbiter_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [7:0] addr,
    output logic       legal,
    output logic       is_load
);

    // Classify the opcode and apply its natural alignment rule.
    always_comb begin
        legal   = 1'b0;
        is_load = 1'b0;
        case (opcode)
            OP_LD: begin
                legal   = (addr[1:0] == 2'b00);
                is_load = 1'b1;
            end
            OP_LDSB, OP_LDUB: begin
                legal   = 1'b1;
                is_load = 1'b1;
            end
            OP_LDSH, OP_LDUH: begin
                legal   = (addr[0] == 1'b0);
                is_load = 1'b1;
            end
            OP_ST: begin
                legal   = (addr[1:0] == 2'b00);
                is_load = 1'b0;
            end
            OP_STB: begin
                legal   = 1'b1;
                is_load = 1'b0;
            end
            OP_STH: begin
                legal   = (addr[0] == 1'b0);
                is_load = 1'b0;
            end
            default: begin
                legal   = 1'b0;
                is_load = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one MFA/MFC handshaked RAM between a fetch
// port and a load/store data port, with a per-phase timeout.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        f_req,
    input  logic [7:0]  f_addr,
    output logic        f_done,
    output logic        f_err,
    output logic [31:0] f_rdata,
    input  logic        d_req,
    input  logic [5:0]  d_opcode,
    input  logic [7:0]  d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_done,
    output logic        d_err,
    output logic [31:0] d_rdata,
    output logic        mem_mfa,
    output logic [5:0]  mem_opcode,
    output logic [7:0]  mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout,
    input  logic        mem_mfc,
    output logic        busy
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    state_t         state_r, state_s;
    port_t          grant_r, grant_s;
    logic [5:0]     op_r;
    logic [7:0]     addr_r;
    logic [31:0]    wdata_r;
    logic [CW-1:0]  cnt_r;
    logic           take_s, issue_s, cnt_clr_s, cnt_inc_s, capture_s, err_s;
    logic           legal_s, is_load_s;

    mem_op_check u_check (
        .opcode  (op_r),
        .addr    (addr_r),
        .legal   (legal_s),
        .is_load (is_load_s)
    );

    // Next-state, arbitration and handshake/timeout decisions.
    always_comb begin
        state_s   = state_r;
        grant_s   = grant_r;
        take_s    = 1'b0;
        issue_s   = 1'b0;
        cnt_clr_s = 1'b0;
        cnt_inc_s = 1'b0;
        capture_s = 1'b0;
        err_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (f_req || d_req) begin
                    take_s  = 1'b1;
                    state_s = ST_CHECK;
                    // grant_r doubles as last-grant: the other port wins a tie.
                    if (f_req && d_req) begin
                        grant_s = (grant_r == PORT_DATA) ? PORT_FETCH : PORT_DATA;
                    end else if (f_req) begin
                        grant_s = PORT_FETCH;
                    end else begin
                        grant_s = PORT_DATA;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (legal_s) begin
                    state_s   = ST_ACCESS;
                    issue_s   = 1'b1;
                    cnt_clr_s = 1'b1;
                end else begin
                    state_s = ST_DONE;
                    err_s   = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (mem_mfc) begin
                    state_s   = ST_RELEASE;
                    cnt_clr_s = 1'b1;
                    capture_s = is_load_s;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = ST_DONE;
                    err_s   = 1'b1;
                end else begin
                    cnt_inc_s = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!mem_mfc) begin
                    state_s = ST_DONE;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = ST_DONE;
                    err_s   = 1'b1;
                end else begin
                    cnt_inc_s = 1'b1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, request latches and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            grant_r    <= PORT_DATA;
            op_r       <= 6'b000000;
            addr_r     <= 8'h00;
            wdata_r    <= 32'h0000_0000;
            cnt_r      <= {CW{1'b0}};
            mem_mfa    <= 1'b0;
            mem_opcode <= 6'b000000;
            mem_addr   <= 8'h00;
            mem_din    <= 32'h0000_0000;
            f_done     <= 1'b0;
            f_err      <= 1'b0;
            f_rdata    <= 32'h0000_0000;
            d_done     <= 1'b0;
            d_err      <= 1'b0;
            d_rdata    <= 32'h0000_0000;
            busy       <= 1'b0;
        end else begin
            state_r <= state_s;
            grant_r <= grant_s;
            if (take_s) begin
                op_r    <= (grant_s == PORT_FETCH) ? OP_FETCH : d_opcode;
                addr_r  <= (grant_s == PORT_FETCH) ? f_addr : d_addr;
                wdata_r <= (grant_s == PORT_FETCH) ? 32'h0000_0000 : d_wdata;
            end
            if (cnt_clr_s) begin
                cnt_r <= {CW{1'b0}};
            end else if (cnt_inc_s) begin
                cnt_r <= cnt_r + CNT_ONE;
            end
            if (issue_s) begin
                mem_opcode <= op_r;
                mem_addr   <= addr_r;
                mem_din    <= wdata_r;
            end
            if (capture_s && (grant_r == PORT_FETCH)) begin
                f_rdata <= mem_dout;
            end
            if (capture_s && (grant_r == PORT_DATA)) begin
                d_rdata <= mem_dout;
            end
            mem_mfa <= (state_s == ST_ACCESS);
            f_done  <= (state_s == ST_DONE) && (grant_r == PORT_FETCH);
            f_err   <= (state_s == ST_DONE) && (grant_r == PORT_FETCH) && err_s;
            d_done  <= (state_s == ST_DONE) && (grant_r == PORT_DATA);
            d_err   <= (state_s == ST_DONE) && (grant_r == PORT_DATA) && err_s;
            busy    <= (state_s != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: byte-addressed big-endian RAM with
// configurable MFC latency, plus a transaction-level reference model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        f_req, d_req;
    logic [7:0]  f_addr, d_addr;
    logic [5:0]  d_opcode;
    logic [31:0] d_wdata;
    logic        f_done, f_err, d_done, d_err;
    logic [31:0] f_rdata, d_rdata;
    logic        mem_mfa, mem_mfc, busy;
    logic [5:0]  mem_opcode;
    logic [7:0]  mem_addr;
    logic [31:0] mem_din;
    wire  [31:0] mem_dout;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_done(f_done), .f_err(f_err), .f_rdata(f_rdata),
        .d_req(d_req), .d_opcode(d_opcode), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_err(d_err), .d_rdata(d_rdata),
        .mem_mfa(mem_mfa), .mem_opcode(mem_opcode), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_mfc(mem_mfc), .busy(busy)
    );

    // ---------------- RAM device ----------------
    logic [7:0]  ram [256];
    logic [31:0] rd;
    logic        ram_init, withhold, mfc_r;
    int          lat, wcnt, mfa_cnt, done_cnt;

    function automatic logic [7:0] init_byte(input int i);
        logic [7:0] pre [4];
        pre = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        if (i >= 16 && i < 20) return pre[i-16];
        return 8'(i * 37 + 11);
    endfunction

    assign mem_mfc  = withhold ? 1'b0 : ((lat == 0) ? mem_mfa : mfc_r);
    assign mem_dout = mem_mfa ? rd : 32'hzzzz_zzzz;

    always_comb begin
        rd = 32'h0;
        case (mem_opcode)
            6'b001000: rd = {ram[mem_addr], ram[mem_addr+8'd1], ram[mem_addr+8'd2], ram[mem_addr+8'd3]};
            6'b001001: rd = {{24{ram[mem_addr][7]}}, ram[mem_addr]};
            6'b000001: rd = {24'h0, ram[mem_addr]};
            6'b001010: rd = {{16{ram[mem_addr][7]}}, ram[mem_addr], ram[mem_addr+8'd1]};
            6'b000010: rd = {16'h0, ram[mem_addr], ram[mem_addr+8'd1]};
            default:   rd = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_byte(i);
        end else if (mem_mfa && mem_mfc) begin
            case (mem_opcode)
                6'b000100: begin
                    ram[mem_addr] <= mem_din[31:24]; ram[mem_addr+8'd1] <= mem_din[23:16];
                    ram[mem_addr+8'd2] <= mem_din[15:8]; ram[mem_addr+8'd3] <= mem_din[7:0];
                end
                6'b000110: begin
                    ram[mem_addr] <= mem_din[15:8]; ram[mem_addr+8'd1] <= mem_din[7:0];
                end
                6'b000101: ram[mem_addr] <= mem_din[7:0];
                default: ;
            endcase
        end
    end

    always @(posedge clk) begin
        if (!mem_mfa) begin
            wcnt  <= 0;
            mfc_r <= 1'b0;
        end else begin
            wcnt <= wcnt + 1;
            if (wcnt + 1 >= lat) mfc_r <= 1'b1;
        end
    end

    always @(posedge clk) begin
        if (mem_mfa) mfa_cnt <= mfa_cnt + 1;
        if (f_done || d_done) done_cnt <= done_cnt + 1;
    end

    initial begin
        mfa_cnt  = 0;
        done_cnt = 0;
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [5:0] op;
        logic [2:0] size;
        logic       load;
        logic       sgn;
    } opinfo_t;

    opinfo_t     optab [8];
    logic [7:0]  shadow [256];
    logic [31:0] exp_rdata [2];
    int          last_port;      // 0 = fetch, 1 = data
    int          checks, errors;

    function automatic bit lookup(input logic [5:0] op, output opinfo_t info);
        info = '0;
        foreach (optab[k]) if (optab[k].op == op) begin info = optab[k]; return 1'b1; end
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input opinfo_t i, input logic [7:0] a);
        logic [31:0] v = 32'h0;
        for (int k = 0; k < int'(i.size); k++) v = (v << 8) | 32'(shadow[8'(int'(a) + k)]);
        if (i.sgn && i.size < 3'd4 && v[8*i.size-1]) v = v | (32'hFFFF_FFFF << (8*i.size));
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction on a single port; timeout expected when withhold is set.
    task automatic do_txn(input int port, input logic [5:0] op_in, input logic [7:0] a,
                          input logic [31:0] wd, input int latency);
        opinfo_t     info;
        logic [5:0]  op;
        bit          legal, seen, to;
        int          n, mfa0;
        logic        oerr;
        logic [31:0] ordata;
        op    = (port == 0) ? 6'b001000 : op_in;
        legal = lookup(op, info) && ((int'(a) % int'(info.size)) == 0);
        to    = legal && withhold;
        lat   = latency;
        @(negedge clk);
        mfa0 = mfa_cnt;
        if (port == 0) begin f_req = 1'b1; f_addr = a; end
        else begin d_req = 1'b1; d_opcode = op; d_addr = a; d_wdata = wd; end
        seen = 1'b0; n = 0; oerr = 1'b0; ordata = 32'h0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            if ((port == 0) ? f_done : d_done) begin
                seen   = 1'b1;
                oerr   = (port == 0) ? f_err : d_err;
                ordata = (port == 0) ? f_rdata : d_rdata;
                f_req  = 1'b0;
                d_req  = 1'b0;
            end
        end
        f_req = 1'b0; d_req = 1'b0;
        if (legal && !to && info.load) exp_rdata[port] = model_load(info, a);
        if (legal && !to && !info.load)
            for (int k = 0; k < int'(info.size); k++)
                shadow[8'(int'(a) + k)] = 8'(wd >> (8 * (int'(info.size) - 1 - k)));
        last_port = port;
        chk("done_seen", 32'(seen), 32'd1);
        chk("err", 32'(oerr), (legal && !to) ? 32'd0 : 32'd1);
        chk("rdata", ordata, exp_rdata[port]);
        if (!legal) chk("mfa_illegal", 32'(mfa_cnt - mfa0), 32'd0);
        if (to) chk("mfa_timeout", 32'(mfa_cnt - mfa0), 32'd16);
        if (legal && !to && latency == 0) begin
            chk("latency", 32'(n), 32'd4);
            chk("mfa_width", 32'(mfa_cnt - mfa0), 32'd1);
        end
        if (legal) begin
            chk("mem_opcode", 32'(mem_opcode), 32'(op));
            chk("mem_addr", 32'(mem_addr), 32'(a));
            if (port == 1) chk("mem_din", mem_din, wd);
        end
        @(negedge clk);
        chk("done_pulse", 32'(f_done | d_done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    // Simultaneous fetch + data load; checks grant order and both results.
    task automatic do_pair(input logic [7:0] fa, input logic [5:0] dop, input logic [7:0] da);
        opinfo_t fi, di;
        int      order [$];
        int      n, first;
        bit      ok;
        ok = lookup(6'b001000, fi);
        ok = lookup(dop, di);
        lat = $urandom_range(0, 2);
        first = (last_port == 1) ? 0 : 1;
        @(negedge clk);
        f_req = 1'b1; f_addr = fa;
        d_req = 1'b1; d_opcode = dop; d_addr = da; d_wdata = $urandom;
        n = 0;
        while (order.size() < 2 && n < 200) begin
            @(negedge clk);
            n++;
            if (f_done) begin
                order.push_back(0); f_req = 1'b0;
                chk("pair_f_err", 32'(f_err), 32'd0);
                chk("pair_f_rdata", f_rdata, model_load(fi, fa));
            end
            if (d_done) begin
                order.push_back(1); d_req = 1'b0;
                chk("pair_d_err", 32'(d_err), 32'd0);
                chk("pair_d_rdata", d_rdata, model_load(di, da));
            end
        end
        f_req = 1'b0; d_req = 1'b0;
        exp_rdata[0] = model_load(fi, fa);
        exp_rdata[1] = model_load(di, da);
        chk("pair_count", 32'(order.size()), 32'd2);
        if (order.size() == 2) begin
            chk("grant_first", 32'(order[0]), 32'(first));
            chk("grant_second", 32'(order[1]), 32'(1 - first));
            last_port = order[1];
        end
        @(negedge clk);
    endtask

    initial begin
        int          n, d0;
        logic [5:0]  rop;
        logic [7:0]  ra;
        logic [5:0]  bad [2];
        optab[0] = '{6'b001000, 3'd4, 1'b1, 1'b0};
        optab[1] = '{6'b001001, 3'd1, 1'b1, 1'b1};
        optab[2] = '{6'b001010, 3'd2, 1'b1, 1'b1};
        optab[3] = '{6'b000001, 3'd1, 1'b1, 1'b0};
        optab[4] = '{6'b000010, 3'd2, 1'b1, 1'b0};
        optab[5] = '{6'b000100, 3'd4, 1'b0, 1'b0};
        optab[6] = '{6'b000101, 3'd1, 1'b0, 1'b0};
        optab[7] = '{6'b000110, 3'd2, 1'b0, 1'b0};
        bad = '{6'b000011, 6'b000111};
        checks = 0; errors = 0;
        for (int i = 0; i < 256; i++) shadow[i] = init_byte(i);
        exp_rdata = '{32'h0, 32'h0};
        last_port = 1;
        reset = 1'b1; ram_init = 1'b1; withhold = 1'b0; lat = 0;
        f_req = 1'b0; d_req = 1'b0; f_addr = 8'h0; d_addr = 8'h0; d_opcode = 6'h0; d_wdata = 32'h0;
        repeat (2) @(negedge clk);
        ram_init = 1'b0;
        chk("rst_mfa", 32'(mem_mfa), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'({f_done, f_err, d_done, d_err}), 32'd0);
        chk("rst_f_rdata", f_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chk("rst_mem_bus", {18'h0, mem_opcode, mem_addr}, 32'h0);
        chk("rst_mem_din", mem_din, 32'h0);
        reset = 1'b0;

        do_txn(0, 6'b001000, 8'h10, 32'h0, 0);
        chk("fetch_deadbeef", f_rdata, 32'hDEAD_BEEF);
        do_txn(1, 6'b000100, 8'h20, 32'h1234_5678, 0);
        do_txn(1, 6'b001010, 8'h22, 32'h0, 0);
        chk("ldsh_5678", d_rdata, 32'h0000_5678);
        do_txn(1, 6'b000011, 8'h24, 32'h0, 0);
        do_txn(1, 6'b000100, 8'h21, 32'hCAFE_F00D, 0);

        for (int r = 0; r < 3; r++) do_pair(8'(8'h10 + 8'(4 * r)), 6'b001000, 8'h20);

        withhold = 1'b1;
        do_txn(1, 6'b001000, 8'h30, 32'h0, 0);
        withhold = 1'b0;
        do_txn(0, 6'b001000, 8'h10, 32'h0, 0);

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 9) < 7) rop = optab[$urandom_range(0, 7)].op;
            else if ($urandom_range(0, 1) == 0) rop = bad[$urandom_range(0, 1)];
            else rop = 6'($urandom);
            ra = 8'($urandom_range(64, 127));
            if ($urandom_range(0, 3) != 0) ra = ra & ~8'(($urandom_range(0, 1) == 0) ? 1 : 3);
            do_txn($urandom_range(0, 1), rop, ra, $urandom, $urandom_range(0, 3));
        end

        withhold = 1'b1;
        @(negedge clk);
        d_req = 1'b1; d_opcode = 6'b001000; d_addr = 8'h40; d_wdata = 32'h0;
        n = 0;
        while (!mem_mfa && n < 50) begin @(negedge clk); n++; end
        chk("abort_reach_access", 32'(mem_mfa), 32'd1);
        repeat (3) @(negedge clk);
        d0 = done_cnt;
        #2 reset = 1'b1;
        #1;
        chk("abort_mfa_async", 32'(mem_mfa), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0; d_req = 1'b0; withhold = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        chk("abort_idle", 32'(busy), 32'd0);
        chk("abort_d_rdata", d_rdata, 32'h0);
        exp_rdata = '{32'h0, 32'h0};
        last_port = 1;
        do_pair(8'h14, 6'b000010, 8'h22);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
